nibble_serial_alu_seq: RTL and testbench



---
 rtl/nibble_serial_alu_seq.sv | 131 +++++++++++++
 tb/tb_nibble_serial_alu_seq.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_alu_seq.sv
// Nibble-serial WIDTH-bit add/sub: one 4-bit adder, LSB nibble first, carry held in a register.
// Ports: clk, reset (async, active-high), start/op_sub/a/b in; ready, valid, sum, carry_out out.
// Optional macro SERIAL_ALU_FLAGS_EN adds registered zero/negative/overflow outputs.

module adder4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);
  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {4'b0, cin};
endmodule

module nibble_serial_alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op_sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ALU_FLAGS_EN
  output logic             carry_out,
  output logic             zero,
  output logic             negative,
  output logic             overflow
`else
  output logic             carry_out
`endif
);
  localparam int NIBBLES = WIDTH / 4;
  localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0] a_reg, b_reg;
  logic             carry_reg;
  logic [CW-1:0]    count;
  logic [3:0]       nib;
  logic             c4;
  logic             last;
  logic [WIDTH+3:0] sum_cat;
  logic [WIDTH-1:0] sum_shift;

  adder4 u_add (
    .a   (a_reg[3:0]),
    .b   (b_reg[3:0]),
    .cin (carry_reg),
    .sum (nib),
    .cout(c4)
  );

  assign last      = (count == CW'(NIBBLES - 1));
  // New nibble enters at the top; after NIBBLES shifts it is in place.
  assign sum_cat   = {nib, sum};
  assign sum_shift = sum_cat[WIDTH+3:4];

  assign ready = (state_q == IDLE);
  assign valid = (state_q == DONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last)  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_reg     <= '0;
      b_reg     <= '0;
      carry_reg <= 1'b0;
      count     <= '0;
      sum       <= '0;
      carry_out <= 1'b0;
`ifdef SERIAL_ALU_FLAGS_EN
      zero      <= 1'b0;
      negative  <= 1'b0;
      overflow  <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            a_reg     <= a;
            b_reg     <= b ^ {WIDTH{op_sub}};
            carry_reg <= op_sub;
            count     <= '0;
            sum       <= '0;
          end
        end
        RUN: begin
          sum       <= sum_shift;
          a_reg     <= a_reg >> 4;
          b_reg     <= b_reg >> 4;
          carry_reg <= c4;
          count     <= count + CW'(1);
          if (last) begin
            carry_out <= c4;
`ifdef SERIAL_ALU_FLAGS_EN
            // On the last nibble a_reg[3]/b_reg[3] are the operand MSBs.
            zero      <= (sum_shift == '0);
            negative  <= nib[3];
            overflow  <= (a_reg[3] == b_reg[3]) && (nib[3] != a_reg[3]);
`endif
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_nibble_serial_alu_seq.sv
// Directed bench for nibble_serial_alu_seq (WIDTH=32).
// Vector table plus hand sequences for ignored start, reset abort, back-to-back.

module tb_nibble_serial_alu_seq;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         op_sub;
  logic [W-1:0] a, b;
  logic         ready, valid;
  logic [W-1:0] sum;
  logic         carry_out;
`ifdef SERIAL_ALU_FLAGS_EN
  logic         zero, negative, overflow;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  nibble_serial_alu_seq #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op_sub   (op_sub),
    .a        (a),
    .b        (b),
    .ready    (ready),
    .valid    (valid),
    .sum      (sum),
`ifdef SERIAL_ALU_FLAGS_EN
    .carry_out(carry_out),
    .zero     (zero),
    .negative (negative),
    .overflow (overflow)
`else
    .carry_out(carry_out)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] s;
    logic         c;
    logic         z;
    logic         n;
    logic         v;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept one op, then wait for valid; returns cycles from acceptance.
  task automatic run_op(input logic s, input logic [W-1:0] x,
                        input logic [W-1:0] y, output int lat);
    bit rdy_low;
    op_sub = s; a = x; b = y; start = 1'b1;
    tick();
    start = 1'b0;
    lat = -1;
    rdy_low = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      if (ready) rdy_low = 1'b0;
      tick();
      if (valid) begin
        lat = k;
        break;
      end
    end
    chk("ready_low_in_run", 64'(rdy_low), 64'd1);
  endtask

  initial begin
    int lat;
    int pulses;
    int vcyc[$];
    logic [W-1:0] exp3[3];
    logic [W-1:0] held;

    vecs[0] = '{1'b0, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[3] = '{1'b1, 32'h0000_0007, 32'h0000_0005, 32'h0000_0002, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[6] = '{1'b1, 32'h1234_5678, 32'h1234_5678, 32'h0000_0000, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 1'b0, 1'b0};

    reset = 1'b1; start = 1'b0; op_sub = 1'b0; a = '0; b = '0;
    tick();
    tick();
    chk("rst_ready", 64'(ready), 64'd1);
    chk("rst_valid", 64'(valid), 64'd0);
    chk("rst_sum", 64'(sum), 64'd0);
    chk("rst_carry", 64'(carry_out), 64'd0);
    reset = 1'b0;
    tick();

    foreach (vecs[i]) begin
      run_op(vecs[i].sub, vecs[i].a, vecs[i].b, lat);
      chk($sformatf("v%0d_latency", i), 64'(lat), 64'd8);
      chk($sformatf("v%0d_sum", i), 64'(sum), 64'(vecs[i].s));
      chk($sformatf("v%0d_carry", i), 64'(carry_out), 64'(vecs[i].c));
`ifdef SERIAL_ALU_FLAGS_EN
      chk($sformatf("v%0d_zero", i), 64'(zero), 64'(vecs[i].z));
      chk($sformatf("v%0d_neg", i), 64'(negative), 64'(vecs[i].n));
      chk($sformatf("v%0d_ovf", i), 64'(overflow), 64'(vecs[i].v));
`endif
      tick();
      chk($sformatf("v%0d_valid_1cyc", i), 64'(valid), 64'd0);
      chk($sformatf("v%0d_ready_back", i), 64'(ready), 64'd1);
      chk($sformatf("v%0d_sum_held", i), 64'(sum), 64'(vecs[i].s));
    end

    // start pulses while busy must be ignored
    op_sub = 1'b0; a = 32'h1234_5678; b = 32'h1111_1111; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    start = 1'b1; op_sub = 1'b1; a = 32'hDEAD_BEEF; b = 32'h0BAD_F00D;
    tick();
    start = 1'b0;
    pulses = 0;
    for (int k = 0; k < 20; k++) begin
      if (valid) begin
        pulses++;
        chk("busy_sum", 64'(sum), 64'h2345_6789);
        chk("busy_carry", 64'(carry_out), 64'd0);
        start = 1'b1; a = 32'hFFFF_0000; b = 32'h0000_FFFF;
        tick();
        start = 1'b0;
      end else begin
        tick();
      end
    end
    chk("busy_single_pulse", 64'(pulses), 64'd1);
    chk("busy_idle_after", 64'(ready), 64'd1);
    chk("busy_sum_kept", 64'(sum), 64'h2345_6789);

    // reset in RUN cycle 4 aborts
    op_sub = 1'b0; a = 32'hAAAA_AAAA; b = 32'h5555_5555; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    reset = 1'b1;
    #1;
    chk("abort_ready", 64'(ready), 64'd1);
    chk("abort_valid", 64'(valid), 64'd0);
    chk("abort_sum", 64'(sum), 64'd0);
    tick();
    chk("abort_hold_sum", 64'(sum), 64'd0);
    chk("abort_hold_valid", 64'(valid), 64'd0);
    reset = 1'b0;
    tick();
    run_op(1'b0, 32'h0000_000F, 32'h0000_0001, lat);
    chk("post_rst_latency", 64'(lat), 64'd8);
    chk("post_rst_sum", 64'(sum), 64'h0000_0010);
    chk("post_rst_carry", 64'(carry_out), 64'd0);
    tick();

    // back-to-back with start held high
    exp3[0] = 32'h0000_0003;
    exp3[1] = 32'h0000_01FF;
    exp3[2] = 32'h0000_0010;
    op_sub = 1'b0; a = 32'h1; b = 32'h2; start = 1'b1;
    tick();
    a = 32'h100; b = 32'h0FF;
    held = '0;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (c == 10) begin a = 32'hFFFF_FFF0; b = 32'h20; end
      if (c == 20) start = 1'b0;
      if (valid) begin
        if (vcyc.size() < 3)
          chk($sformatf("b2b_sum%0d", vcyc.size()), 64'(sum),
              64'(exp3[vcyc.size()]));
        vcyc.push_back(c);
        held = sum;
      end else if (vcyc.size() > 0 && c == vcyc[vcyc.size()-1] + 1) begin
        chk("b2b_sum_stable", 64'(sum), 64'(held));
      end
    end
    chk("b2b_pulses", 64'(vcyc.size()), 64'd3);
    if (vcyc.size() == 3) begin
      chk("b2b_first", 64'(vcyc[0]), 64'd8);
      chk("b2b_gap1", 64'(vcyc[1] - vcyc[0]), 64'd10);
      chk("b2b_gap2", 64'(vcyc[2] - vcyc[1]), 64'd10);
    end
    chk("b2b_carry_last", 64'(carry_out), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
